// File: rtl/credential_check_unit.sv
// Compares a candidate against a stored credential through an external ALU and keeps a score counter.
// Build option CCU_LOCKOUT_EN adds consecutive-failure lockout (fail counter, LOCK state, lock timer).
module credential_check_unit #(
  parameter int WIDTH       = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             cred_load_i,
  input  logic [WIDTH-1:0] cred_in_i,
  output logic [WIDTH-1:0] alu_iA_o,
  output logic [WIDTH-1:0] alu_iB_o,
  output logic [3:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_r_i,
  input  logic [4:0]       alu_status_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             match_o,
  output logic             led_o,
  output logic [WIDTH-1:0] counter_o,
  output logic             locked_o
);
  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_INC, S_DEC, S_WB, S_HIT, S_LOCK} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cred_q, cred_d, ia_q, ia_d, ib_q, ib_d, cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             match_q, match_d, led_q, led_d, done_q, done_d;
  logic             locked;

  // Only zero and the signed less-than pair (negative ^ overflow) steer the FSM.
  logic unused_status;
  assign unused_status = alu_status_i[2] ^ alu_status_i[0];

`ifdef CCU_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lock_q, lock_d;
  assign locked = lock_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_FAIL == 0) || (LOCK_CYCLES == 0);
  assign locked     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cred_q  <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCU_LOCKOUT_EN
      fail_q  <= '0;
      timer_q <= '0;
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      led_q   <= led_d;
      done_q  <= done_d;
`ifdef CCU_LOCKOUT_EN
      fail_q  <= fail_d;
      timer_q <= timer_d;
      lock_q  <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cred_d  = cred_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    led_d   = led_q;
    done_d  = 1'b0;
`ifdef CCU_LOCKOUT_EN
    fail_d  = fail_q;
    timer_d = timer_q;
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cred_load_i) begin
          cred_d = cred_in_i;
          led_d  = 1'b0;
        end else if (start_i && !locked) begin
          ia_d    = data_in_i;
          ib_d    = cred_q;
          op_d    = OP_SUB;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (alu_status_i[4])                     state_d = S_HIT;
        else if (alu_status_i[3] ^ alu_status_i[1]) state_d = S_INC;
        else                                     state_d = S_DEC;
      end
      S_INC: begin
        ia_d    = cnt_q;
        ib_d    = WIDTH'(1);
        op_d    = OP_ADD;
        state_d = S_WB;
      end
      S_DEC: begin
        ia_d    = cnt_q;
        ib_d    = WIDTH'(1);
        op_d    = OP_SUB;
        state_d = S_WB;
      end
      S_WB: begin
        cnt_d   = alu_r_i;
        match_d = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef CCU_LOCKOUT_EN
        fail_d = fail_q + FW'(1);
        if (fail_d == FW'(MAX_FAIL)) begin
          lock_d  = 1'b1;
          timer_d = '0;
          state_d = S_LOCK;
        end
`endif
      end
      S_HIT: begin
        match_d = 1'b1;
        led_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef CCU_LOCKOUT_EN
        fail_d = '0;
`endif
      end
      S_LOCK: begin
`ifdef CCU_LOCKOUT_EN
        // Timer enters at 0, so the final count is LOCK_CYCLES-1.
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          lock_d  = 1'b0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_iA_o  = ia_q;
  assign alu_iB_o  = ib_q;
  assign alu_op_o  = op_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign match_o   = match_q;
  assign led_o     = led_q;
  assign counter_o = cnt_q;
  assign locked_o  = locked;
endmodule

// File: tb/tb_credential_check_unit.sv
// Directed bench for credential_check_unit: external ALU model, attempt-level reference model, per-cycle compare.
module tb_credential_check_unit;
  localparam int W = 4, MAX_FAIL = 3, LOCK_CYCLES = 16;
`ifdef CCU_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, cred_load = 1'b0;
  logic [W-1:0] data = '0, cred_in = '0;
  logic [W-1:0] alu_iA, alu_iB, alu_r, counter;
  logic [3:0] alu_op;
  logic [4:0] alu_status;
  logic busy, done, match, led, locked;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  credential_check_unit #(.WIDTH(W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .data_in_i(data),
    .cred_load_i(cred_load), .cred_in_i(cred_in),
    .alu_iA_o(alu_iA), .alu_iB_o(alu_iB), .alu_op_o(alu_op),
    .alu_r_i(alu_r), .alu_status_i(alu_status),
    .busy_o(busy), .done_o(done), .match_o(match), .led_o(led),
    .counter_o(counter), .locked_o(locked));

  // External ALU: op 13 adds, anything else subtracts; status {zero, neg, carry, ovf, parity}.
  always_comb begin
    logic [W:0] ext;
    logic v;
    ext = '0;
    v   = 1'b0;
    if (alu_op == 4'd13) begin
      ext = {1'b0, alu_iA} + {1'b0, alu_iB};
      v   = (alu_iA[W-1] == alu_iB[W-1]) && (ext[W-1] != alu_iA[W-1]);
    end else begin
      ext = {1'b0, alu_iA} + {1'b0, ~alu_iB} + 1'b1;
      v   = (alu_iA[W-1] != alu_iB[W-1]) && (ext[W-1] != alu_iA[W-1]);
    end
    alu_r      = ext[W-1:0];
    alu_status = {(ext[W-1:0] == '0), ext[W-1], ext[W], v, ^ext[W-1:0]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Attempt-level reference: results appear together on the done cycle,
  // hit 2 edges after the accepting edge, miss 3 edges; lockout follows the failing done.
  int m_left, m_lock, m_fails;
  logic [W-1:0] m_cred, m_cnt, m_res_cnt;
  logic m_hit, m_match, m_led, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_lock <= 0; m_fails <= 0;
      m_cred <= '0; m_cnt <= '0; m_res_cnt <= '0;
      m_hit <= 1'b0; m_match <= 1'b0; m_led <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          if (m_hit) begin
            m_match <= 1'b1; m_led <= 1'b1; m_fails <= 0;
          end else begin
            m_match <= 1'b0;
            m_cnt   <= m_res_cnt;
            if (LOCK_EN && m_fails + 1 == MAX_FAIL) begin
              m_lock <= LOCK_CYCLES; m_fails <= 0;
            end else begin
              m_fails <= m_fails + 1;
            end
          end
        end
      end else if (m_lock > 0) begin
        m_lock <= m_lock - 1;
      end else if (cred_load) begin
        m_cred <= cred_in; m_led <= 1'b0;
      end else if (start) begin
        m_hit <= (data == m_cred);
        if (data == m_cred) m_left <= 2;
        else begin
          m_left    <= 3;
          m_res_cnt <= ($signed(data) < $signed(m_cred)) ? m_cnt + 1'b1 : m_cnt - 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (m_left > 0 || m_lock > 0));
      chk("done", done, m_done);
      chk("match", match, m_match);
      chk("led", led, m_led);
      chk("counter", counter, m_cnt);
      chk("locked", locked, (m_lock > 0));
    end
  end

  // Launch one attempt; latency counted in negedges after the accepting edge.
  task automatic attempt(input logic [W-1:0] d, input int exp_lat, input string nm);
    int lat;
    @(negedge clk); start = 1'b1; data = d;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk(nm, lat, exp_lat);
  endtask

  task automatic load(input logic [W-1:0] c);
    @(negedge clk); cred_load = 1'b1; cred_in = c;
    @(negedge clk); cred_load = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_led", led, 0);     chk("rst_cnt", counter, 0);
    chk("rst_locked", locked, 0); chk("rst_op", alu_op, 0);
    rst_n = 1'b1;

    // cred_load wins over start in the same cycle
    @(negedge clk); cred_load = 1'b1; cred_in = 4'd9; start = 1'b1; data = 4'd9;
    @(negedge clk); cred_load = 1'b0; start = 1'b0;
    chk("ld_busy", busy, 0);
    repeat (4) @(negedge clk);
    attempt(4'd9, 3, "lat_hit_cred9");
    chk("hit9_match", match, 1);

    load(4'd5);
    chk("ld_led_clr", led, 0);
    attempt(4'd5, 3, "lat_hit5");
    chk("hit5_match", match, 1); chk("hit5_led", led, 1); chk("hit5_cnt", counter, 0);

    attempt(4'd2, 4, "lat_miss2");
    chk("miss2_cnt", counter, 1); chk("miss2_match", match, 0);
    attempt(4'd7, 4, "lat_miss7a");
    chk("miss7a_cnt", counter, 0);
    attempt(4'd7, 4, "lat_miss7b");
    chk("wrap_down_cnt", counter, 15);

`ifdef CCU_LOCKOUT_EN
    chk("lock_entry", locked, 1);
    cnt = 0;
    while (locked && cnt < 40) begin
      if (cnt == 3) begin start = 1'b1; data = 4'd5; end else start = 1'b0;
      @(negedge clk); cnt++;
    end
    start = 1'b0;
    chk("lock_len", cnt, LOCK_CYCLES);
    chk("lock_cnt_hold", counter, 15);
    attempt(4'd5, 3, "lat_post_lock");
    attempt(4'd9, 4, "lat_neg_data");
    chk("wrap_up_cnt", counter, 0);
`else
    attempt(4'd9, 4, "lat_miss9");
    chk("wrap_up_cnt", counter, 0);
    attempt(4'd3, 4, "lat_miss3");
    chk("nolock_locked", locked, 0);
    attempt(4'd5, 3, "lat_hit_tail");
    attempt(4'd9, 4, "lat_neg_data");
    chk("neg_data_cnt", counter, 2);
`endif

    // Reset while in INC aborts the attempt and clears everything at once
    @(negedge clk); start = 1'b1; data = 4'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);   chk("ar_done", done, 0);
    chk("ar_match", match, 0); chk("ar_led", led, 0);
    chk("ar_cnt", counter, 0); chk("ar_locked", locked, 0);
    chk("ar_ia", alu_iA, 0);   chk("ar_ib", alu_iB, 0);
    @(negedge clk); rst_n = 1'b1;
    attempt(4'd0, 3, "lat_after_reset");
    chk("ar_hit_match", match, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
